// File: rtl/demux_stream_1xn_pkg.sv
// Shared definitions for the 1xN stream demultiplexer.
package demux_stream_1xn_pkg;

  // Packet-lock FSM: IDLE waits for a packet head, PKT holds the latched channel.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_e;

  // Select width; a single-channel demux still carries a 1-bit select.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/demux_stream_1xn_slot.sv
// One-entry output register slice: loads a beat, drains on consumer ready.
module demux_out_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         drain,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         last
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         last_q, last_d;

  // Load wins over drain so a simultaneous drain+load keeps the slot full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (valid_q && drain) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers; data and last hold after a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign last  = last_q;

endmodule

// File: rtl/demux_stream_1xn.sv
// Registered 1-to-N stream demultiplexer with packet lock and drop counting.
module demux_stream_1xn
  import demux_stream_1xn_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int W    = 8,
  parameter  int CNTW = 16,
  localparam int SELW = sel_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    in_data,
  input  logic            in_valid,
  input  logic            in_last,
  input  logic [SELW-1:0] sel,
  output logic            in_ready,
  output logic [N*W-1:0]  out_data,
  output logic [N-1:0]    out_valid,
  output logic [N-1:0]    out_last,
  input  logic [N-1:0]    out_ready,
  output logic            busy,
  output logic [CNTW-1:0] drop_cnt
);

  state_e          state_q, state_d;
  logic [SELW-1:0] cur_sel_q, cur_sel_d;
  logic [CNTW-1:0] drop_q, drop_d;
  logic            busy_q, busy_d;
  logic [SELW-1:0] eff;
  logic            eff_in_range;
  logic            accept;
  logic [N-1:0]    load;

  // Routing target and input flow control: out-of-range beats are always taken.
  always_comb begin
    eff          = (state_q == ST_PKT) ? cur_sel_q : sel;
    eff_in_range = (int'(eff) < N);
    in_ready     = 1'b1;
    if (eff_in_range) begin
      in_ready = ~out_valid[eff] | out_ready[eff];
    end
    accept = in_valid & in_ready;
  end

  // Packet lock, channel latch and saturating drop counter.
  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    drop_d    = drop_q;
    if (accept) begin
      if (state_q == ST_IDLE) begin
        cur_sel_d = sel;
      end
      state_d = in_last ? ST_IDLE : ST_PKT;
      if (!eff_in_range && (drop_q != '1)) begin
        drop_d = drop_q + 1'b1;
      end
    end
    busy_d = (state_d == ST_PKT);
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_sel_q <= '0;
      drop_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      drop_q    <= drop_d;
      busy_q    <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign drop_cnt = drop_q;

  for (genvar i = 0; i < N; i++) begin : g_slot
    assign load[i] = accept & eff_in_range & (eff == SELW'(i));

    demux_out_slot #(.W(W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[i]),
      .load_data (in_data),
      .load_last (in_last),
      .drain     (out_ready[i]),
      .valid     (out_valid[i]),
      .data      (out_data[i*W +: W]),
      .last      (out_last[i])
    );
  end

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Self-checking bench: an 8-channel and a 6-channel (2-bit drop counter) instance
// driven in lockstep, each checked against a queue-based reference model.
module tb_demux_stream_1xn;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [2:0] sel = '0;
  logic [7:0] in_data = '0;
  logic [7:0] out_ready = '0;

  logic        rdy8, busy8;
  logic [63:0] od8;
  logic [7:0]  ov8, ol8;
  logic [15:0] dc8;

  logic        rdy6, busy6;
  logic [47:0] od6;
  logic [5:0]  ov6, ol6;
  logic [1:0]  dc6;

  always #5 clk = ~clk;

  demux_stream_1xn #(.N(8), .W(8), .CNTW(16)) dut8 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .sel(sel), .in_ready(rdy8), .out_data(od8), .out_valid(ov8), .out_last(ol8),
    .out_ready(out_ready), .busy(busy8), .drop_cnt(dc8)
  );

  demux_stream_1xn #(.N(6), .W(8), .CNTW(2)) dut6 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .sel(sel), .in_ready(rdy6), .out_data(od6), .out_valid(ov6), .out_last(ol6),
    .out_ready(out_ready[5:0]), .busy(busy6), .drop_cnt(dc6)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: per-instance packet lock, per-channel delivery queue,
  // last-delivered value per channel and a saturating drop count.
  int          nch  [2] = '{8, 6};
  int unsigned dmax [2] = '{65535, 3};
  logic        m_busy [2];
  logic [2:0]  m_sel  [2];
  int unsigned m_drop [2];
  logic [8:0]  mq     [16][$];
  logic [8:0]  m_hold [16];
  logic        seen_rdy [2];

  function automatic logic get_v(int k, int i);
    return (k == 0) ? ov8[i] : ov6[i];
  endfunction
  function automatic logic [8:0] get_dl(int k, int i);
    return (k == 0) ? {ol8[i], od8[i*8 +: 8]} : {ol6[i], od6[i*8 +: 8]};
  endfunction
  function automatic logic get_rdy(int k);
    return (k == 0) ? rdy8 : rdy6;
  endfunction
  function automatic logic get_busy(int k);
    return (k == 0) ? busy8 : busy6;
  endfunction
  function automatic logic [15:0] get_drop(int k);
    return (k == 0) ? dc8 : 16'(dc6);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0;
      m_sel[k]  = '0;
      m_drop[k] = 0;
    end
    for (int j = 0; j < 16; j++) begin
      mq[j].delete();
      m_hold[j] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_ov8", 64'(ov8), 64'(0));
    chk("rst_ov6", 64'(ov6), 64'(0));
    chk("rst_busy8", 64'(busy8), 64'(0));
    chk("rst_busy6", 64'(busy6), 64'(0));
    chk("rst_drop8", 64'(dc8), 64'(0));
    chk("rst_drop6", 64'(dc6), 64'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock of stimulus: in_ready checked before the edge, outputs after it.
  task automatic step(input logic v, input logic l, input logic [2:0] s,
                      input logic [7:0] d, input logic [7:0] r);
    logic [2:0] e [2];
    logic       acc [2];
    logic       er;
    @(negedge clk);
    in_valid = v; in_last = l; sel = s; in_data = d; out_ready = r;
    #1;
    for (int k = 0; k < 2; k++) begin
      e[k] = m_busy[k] ? m_sel[k] : s;
      if (int'(e[k]) >= nch[k]) er = 1'b1;
      else er = (mq[k*8 + int'(e[k])].size() == 0) || r[e[k]];
      seen_rdy[k] = get_rdy(k);
      chk($sformatf("in_ready_d%0d", k), 64'(seen_rdy[k]), 64'(er));
      acc[k] = v && er;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int ch = 0; ch < nch[k]; ch++) begin
        if (mq[k*8 + ch].size() > 0 && r[ch]) void'(mq[k*8 + ch].pop_front());
      end
      if (acc[k]) begin
        if (int'(e[k]) < nch[k]) begin
          mq[k*8 + int'(e[k])].push_back({l, d});
          m_hold[k*8 + int'(e[k])] = {l, d};
        end else if (m_drop[k] < dmax[k]) begin
          m_drop[k]++;
        end
        if (!m_busy[k]) m_sel[k] = s;
        m_busy[k] = !l;
      end
      chk($sformatf("busy_d%0d", k), 64'(get_busy(k)), 64'(m_busy[k]));
      chk($sformatf("drop_d%0d", k), 64'(get_drop(k)), 64'(m_drop[k]));
      for (int ch = 0; ch < nch[k]; ch++) begin
        chk($sformatf("valid_d%0d_ch%0d", k, ch), 64'(get_v(k, ch)),
            64'(mq[k*8 + ch].size() != 0));
        chk($sformatf("data_d%0d_ch%0d", k, ch), 64'(get_dl(k, ch)),
            64'((mq[k*8 + ch].size() != 0) ? mq[k*8 + ch][0] : m_hold[k*8 + ch]));
      end
    end
  endtask

  initial begin
    do_reset();

    // 1-beat packets to every channel with all consumers ready.
    for (int s = 0; s < 8; s++) begin
      step(1'b1, 1'b1, 3'(s), 8'hA0 + 8'(s), 8'hFF);
      chk("t1_onehot", 64'(ov8), 64'(1) << s);
      chk("t1_data", 64'(od8[s*8 +: 8]), 64'(8'hA0 + 8'(s)));
      chk("t1_last", 64'(ol8[s]), 64'(1));
    end

    // Multi-beat packet locks to ch3 even as sel moves to 5.
    step(1'b1, 1'b0, 3'd3, 8'h11, 8'hFF);
    chk("t2_busy_b1", 64'(busy8), 64'(1));
    step(1'b1, 1'b0, 3'd5, 8'h22, 8'hFF);
    chk("t2_ch3_b2", 64'(ov8), 64'(8'h08));
    step(1'b1, 1'b0, 3'd5, 8'h33, 8'hFF);
    chk("t2_busy_b3", 64'(busy8), 64'(1));
    step(1'b1, 1'b1, 3'd5, 8'h44, 8'hFF);
    chk("t2_ch3_b4", 64'(ov8), 64'(8'h08));
    chk("t2_data_b4", 64'(od8[3*8 +: 8]), 64'(8'h44));
    chk("t2_busy_end", 64'(busy8), 64'(0));

    // Back-pressure on ch2.
    step(1'b1, 1'b1, 3'd2, 8'h55, 8'hFB);
    step(1'b1, 1'b1, 3'd2, 8'h66, 8'hFB);
    chk("t3_stall", 64'(seen_rdy[0]), 64'(0));
    chk("t3_held", 64'(od8[2*8 +: 8]), 64'(8'h55));
    step(1'b1, 1'b1, 3'd2, 8'h66, 8'hFF);
    chk("t3_release_rdy", 64'(seen_rdy[0]), 64'(1));
    chk("t3_second", 64'(od8[2*8 +: 8]), 64'(8'h66));
    step(1'b0, 1'b0, 3'd0, 8'h00, 8'hFF);
    chk("t3_drained", 64'(ov8), 64'(0));

    // Out-of-range packet on the 6-channel instance, then a routed beat.
    do_reset();
    step(1'b1, 1'b0, 3'd7, 8'hD1, 8'hFF);
    chk("t4_rdy_b1", 64'(seen_rdy[1]), 64'(1));
    step(1'b1, 1'b0, 3'd1, 8'hD2, 8'hFF);
    chk("t4_rdy_b2", 64'(seen_rdy[1]), 64'(1));
    step(1'b1, 1'b1, 3'd1, 8'hD3, 8'hFF);
    chk("t4_rdy_b3", 64'(seen_rdy[1]), 64'(1));
    chk("t4_no_valid", 64'(ov6), 64'(0));
    chk("t4_drop3", 64'(dc6), 64'(3));
    step(1'b1, 1'b1, 3'd1, 8'h77, 8'hFF);
    chk("t4_ch1", 64'(ov6), 64'(6'b000010));
    chk("t4_ch1_data", 64'(od6[1*8 +: 8]), 64'(8'h77));

    // Drop counter saturation.
    step(1'b1, 1'b1, 3'd7, 8'hE1, 8'hFF);
    step(1'b1, 1'b1, 3'd6, 8'hE2, 8'hFF);
    chk("t5_sat", 64'(dc6), 64'(3));

    // Reset in the middle of a stalled packet.
    step(1'b1, 1'b0, 3'd4, 8'h10, 8'h00);
    step(1'b1, 1'b0, 3'd4, 8'h20, 8'h00);
    chk("t6_busy_pre", 64'(busy8), 64'(1));
    do_reset();
    step(1'b1, 1'b1, 3'd2, 8'h99, 8'hFF);
    chk("t6_new_route", 64'(ov8), 64'(8'h04));
    chk("t6_new_data", 64'(od8[2*8 +: 8]), 64'(8'h99));

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
           3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
